// File: rtl/axi_sitcp_pkg.sv
// Shared types and AXI constants for the SiTCP AXI4-Lite request arbiter.
package axi_sitcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr+1.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest slot back to ptr+1 so the nearest requester is assigned last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr) + k) % N_REQ);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Round-robin sharing of one AXI4-Lite master among N_REQ simple-request clients,
// one transaction in flight at a time, with a per-handshake timeout.
module axil_req_arbiter
  import axi_sitcp_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]           done,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 resp,
  output logic                       timeout_err,
  output logic                       busy,
  output logic [ADDR_W-1:0]          m_axi_awaddr,
  output logic [2:0]                 m_axi_awprot,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [DATA_W-1:0]          m_axi_wdata,
  output logic [DATA_W/8-1:0]        m_axi_wstrb,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  output logic [ADDR_W-1:0]          m_axi_araddr,
  output logic [2:0]                 m_axi_arprot,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DATA_W-1:0]          m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  arb_state_e        state;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win_idx;
  logic [N_REQ-1:0]  win_grant;
  logic [CNT_W-1:0]  tcnt;
  logic              tmo_hit;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              aw_fin;
  logic              w_fin;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (win_grant),
    .idx   (win_idx)
  );

  always_comb begin
    sel_we    = req_we[win_idx];
    sel_addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[win_idx*DATA_W +: DATA_W];
    sel_wstrb = req_wstrb[win_idx*STRB_W +: STRB_W];
  end

  assign m_axi_awprot = AXI_PROT_DEFAULT;
  assign m_axi_arprot = AXI_PROT_DEFAULT;

  // A handshake channel is finished once its valid is gone or is being accepted this cycle.
  assign aw_fin  = !m_axi_awvalid || m_axi_awready;
  assign w_fin   = !m_axi_wvalid  || m_axi_wready;
  assign tmo_hit = (tcnt >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= PTR_W'(N_REQ - 1);
      tcnt          <= '0;
      done          <= '0;
      rdata         <= '0;
      resp          <= RESP_OKAY;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      done        <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|win_grant) begin
            ptr  <= win_idx;
            busy <= 1'b1;
            tcnt <= '0;
            if (sel_we) begin
              m_axi_awaddr  <= sel_addr;
              m_axi_wdata   <= sel_wdata;
              m_axi_wstrb   <= sel_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WR;
            end else begin
              m_axi_araddr  <= sel_addr;
              m_axi_arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end
        end

        ST_WR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            tcnt         <= '0;
            state        <= ST_WR_RESP;
          end else if (tmo_hit) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            done          <= onehot(ptr);
            resp          <= RESP_DECERR;
            timeout_err   <= 1'b1;
            state         <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            resp         <= m_axi_bresp;
            done         <= onehot(ptr);
            state        <= ST_DONE;
          end else if (tmo_hit) begin
            m_axi_bready <= 1'b0;
            done         <= onehot(ptr);
            resp         <= RESP_DECERR;
            timeout_err  <= 1'b1;
            state        <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            tcnt          <= '0;
            state         <= ST_RD_DATA;
          end else if (tmo_hit) begin
            m_axi_arvalid <= 1'b0;
            done          <= onehot(ptr);
            resp          <= RESP_DECERR;
            timeout_err   <= 1'b1;
            state         <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rdata        <= m_axi_rdata;
            resp         <= m_axi_rresp;
            done         <= onehot(ptr);
            state        <= ST_DONE;
          end else if (tmo_hit) begin
            m_axi_rready <= 1'b0;
            done         <= onehot(ptr);
            resp         <= RESP_DECERR;
            timeout_err  <= 1'b1;
            state        <= ST_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        // done is visible this cycle; busy falls and the picker runs again next cycle.
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Scoreboard bench for axil_req_arbiter: directed client requests, a scripted AXI-Lite slave,
// and a negedge monitor checking AXI beats and completions against queued expectations.
`timescale 1ns/1ps
module tb_axil_req_arbiter;

  localparam int N = 2, AW = 32, DW = 32, SW = 4, TMO = 15;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic [1:0]      resp;
  logic            timeout_err, busy;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]      m_axi_awprot, m_axi_arprot;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;

  axil_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .done(done), .rdata(rdata),
    .resp(resp), .timeout_err(timeout_err), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        te;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] ar_q[$];

  int total = 0, bad = 0;
  int cyc = 0, last_done_cyc = -1;
  bit mon_en = 1'b0, gap_chk = 1'b0;

  int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  logic        force_r = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  function automatic logic [N-1:0] oh(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Scripted slave: readies after a configurable number of cycles of valid.
  initial begin : slave
    int aw_cnt, w_cnt, b_cnt, ar_cnt;
    logic [31:0] ar_last;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; ar_last = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (m_axi_awvalid) begin m_axi_awready = (aw_cnt >= cfg_aw_dly); aw_cnt++; end
      else begin m_axi_awready = 1'b0; aw_cnt = 0; end
      if (m_axi_wvalid) begin m_axi_wready = (w_cnt >= cfg_w_dly); w_cnt++; end
      else begin m_axi_wready = 1'b0; w_cnt = 0; end
      if (m_axi_bready) begin m_axi_bvalid = (b_cnt >= cfg_b_dly); m_axi_bresp = cfg_bresp; b_cnt++; end
      else begin m_axi_bvalid = 1'b0; b_cnt = 0; end
      if (m_axi_arvalid) begin m_axi_arready = (ar_cnt >= cfg_ar_dly); ar_last = m_axi_araddr; ar_cnt++; end
      else begin m_axi_arready = 1'b0; ar_cnt = 0; end
      if (m_axi_rready) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = cfg_rdata ^ ar_last;
        m_axi_rresp  = cfg_rresp;
      end else begin
        m_axi_rvalid = force_r;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion and every AXI handshake.
  bit prev_aw_hs = 1'b0, prev_w_hs = 1'b0, prev_bready = 1'b0, prev_arvalid = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (prev_aw_hs) chk("awvalid_drop", 64'(m_axi_awvalid), 64'(0));
      if (prev_w_hs)  chk("wvalid_drop", 64'(m_axi_wvalid), 64'(0));
      if (m_axi_bready && !prev_bready)
        chk("bready_after_aw_w", 64'({m_axi_awvalid, m_axi_wvalid}), 64'(0));
      if (|done) begin
        if (exp_q.size() == 0) fail_evt("unexpected_done");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vec", 64'(done), 64'(oh(e.c)));
          chk("rdata", 64'(rdata), 64'(e.rd));
          chk("resp", 64'(resp), 64'(e.rs));
          chk("timeout_err", 64'(timeout_err), 64'(e.te));
        end
        if (gap_chk) last_done_cyc = cyc;
      end else if (timeout_err) begin
        fail_evt("timeout_err_without_done");
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) fail_evt("unexpected_aw");
        else chk("awaddr", 64'(m_axi_awaddr), 64'(aw_q.pop_front()));
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) fail_evt("unexpected_w");
        else chk("wstrb_wdata", 64'({m_axi_wstrb, m_axi_wdata}), 64'(w_q.pop_front()));
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) fail_evt("unexpected_ar");
        else chk("araddr", 64'(m_axi_araddr), 64'(ar_q.pop_front()));
      end
      if (gap_chk && m_axi_arvalid && !prev_arvalid && last_done_cyc >= 0)
        chk("done_to_arvalid_gap", 64'(cyc - last_done_cyc), 64'(2));
      prev_aw_hs   = m_axi_awvalid && m_axi_awready;
      prev_w_hs    = m_axi_wvalid && m_axi_wready;
      prev_bready  = m_axi_bready;
      prev_arvalid = m_axi_arvalid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (done[i]) req[i] = 1'b0;
  endtask

  task automatic set_client(input int c, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    req_we[c]          = we;
    req_addr[c*AW +: AW]  = a;
    req_wdata[c*DW +: DW] = d;
    req_wstrb[c*SW +: SW] = s;
  endtask

  task automatic expect_done(input int c, input logic [31:0] rd, input logic [1:0] rs, input logic te);
    exp_t e;
    e.c = c; e.rd = rd; e.rs = rs; e.te = te;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((req != '0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(n < budget), 64'(1));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt, guard;
    int rem[N];
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) tick();
    mon_en = 1'b1;
    tick();
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    chk("rst_wvalid", 64'(m_axi_wvalid), 64'(0));
    chk("rst_bready", 64'(m_axi_bready), 64'(0));
    chk("rst_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_rready", 64'(m_axi_rready), 64'(0));
    chk("rst_done_busy_terr", 64'({done, busy, timeout_err}), 64'(0));
    chk("rst_rdata_resp", 64'({rdata, resp}), 64'(0));
    chk("rst_addr_data", 64'({m_axi_awaddr, m_axi_wdata}), 64'(0));
    rst = 1'b0;
    tick();

    // Single write, awready ahead of wready.
    cfg_aw_dly = 0; cfg_w_dly = 2; cfg_bresp = 2'b00;
    set_client(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    aw_q.push_back(32'h0000_0010);
    w_q.push_back({4'hF, 32'hDEAD_BEEF});
    expect_done(0, 32'h0, 2'b00, 1'b0);
    req[0] = 1'b1;
    wait_idle("t1_complete", 100);
    chk("t1_busy_low", 64'(busy), 64'(0));

    // Single read from client 1 with SLVERR.
    cfg_ar_dly = 0; cfg_rdata = 32'h1234_5658; cfg_rresp = 2'b10;
    set_client(1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    ar_q.push_back(32'h0000_0020);
    expect_done(1, 32'h1234_5678, 2'b10, 1'b0);
    req[1] = 1'b1;
    wait_idle("t2_complete", 100);

    // Both clients read continuously; grants must alternate 0,1,0,1,0,1.
    cfg_rdata = 32'hCAFE_0000; cfg_rresp = 2'b00;
    set_client(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    set_client(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        ar_q.push_back(32'h0000_0100);
        expect_done(0, 32'hCAFE_0100, 2'b00, 1'b0);
      end else begin
        ar_q.push_back(32'h0000_0200);
        expect_done(1, 32'hCAFE_0200, 2'b00, 1'b0);
      end
    end
    last_done_cyc = -1;
    gap_chk = 1'b1;
    rem[0] = 2; rem[1] = 2;
    req = 2'b11;
    guard = 0;
    while (!(rem[0] == 0 && rem[1] == 0 && req == '0 && !busy) && guard < 300) begin
      tick();
      for (int c = 0; c < N; c++)
        if (!req[c] && rem[c] > 0) begin
          req[c] = 1'b1;
          rem[c]--;
        end
      guard++;
    end
    chk("t3_complete", 64'(guard < 300), 64'(1));
    gap_chk = 1'b0;

    // Write with wready 3 cycles ahead of awready, then both readies in the same cycle.
    cfg_aw_dly = 3; cfg_w_dly = 0; cfg_bresp = 2'b10;
    set_client(1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3);
    aw_q.push_back(32'h0000_0040);
    w_q.push_back({4'h3, 32'h0BAD_F00D});
    expect_done(1, 32'hCAFE_0200, 2'b10, 1'b0);
    req[1] = 1'b1;
    wait_idle("t4a_complete", 100);
    cfg_aw_dly = 2; cfg_w_dly = 2; cfg_bresp = 2'b00;
    set_client(0, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 4'hC);
    aw_q.push_back(32'h0000_0044);
    w_q.push_back({4'hC, 32'h5555_AAAA});
    expect_done(0, 32'hCAFE_0200, 2'b00, 1'b0);
    req[0] = 1'b1;
    wait_idle("t4b_complete", 100);

    // arready never comes: abort after TIMEOUT cycles of arvalid.
    cfg_ar_dly = 1000;
    set_client(0, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    expect_done(0, 32'hCAFE_0200, 2'b11, 1'b1);
    req[0] = 1'b1;
    guard = 0;
    while (!m_axi_arvalid && guard < 10) begin tick(); guard++; end
    cnt = 0;
    while (m_axi_arvalid && cnt < 100) begin cnt++; tick(); end
    chk("t5_arvalid_cycles", 64'(cnt), 64'(TMO));
    wait_idle("t5_complete", 50);
    force_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_rready_idle", 64'(m_axi_rready), 64'(0));
    end
    force_r = 1'b0;
    repeat (2) tick();
    cfg_ar_dly = 1; cfg_rdata = 32'h0F0F_0000;
    set_client(1, 1'b0, 32'h0000_0034, 32'h0, 4'h0);
    ar_q.push_back(32'h0000_0034);
    expect_done(1, 32'h0F0F_0034, 2'b00, 1'b0);
    req[1] = 1'b1;
    wait_idle("t5_next_complete", 100);

    // Reset while waiting for bvalid; client 0 must then win ahead of client 1.
    cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 1000;
    set_client(0, 1'b1, 32'h0000_0050, 32'h1122_3344, 4'hF);
    aw_q.push_back(32'h0000_0050);
    w_q.push_back({4'hF, 32'h1122_3344});
    req[0] = 1'b1;
    guard = 0;
    while (!m_axi_bready && guard < 50) begin tick(); guard++; end
    chk("t6_in_wr_resp", 64'(m_axi_bready), 64'(1));
    rst = 1'b1;
    req = '0;
    tick();
    chk("t6_valids_after_rst", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
    chk("t6_readies_after_rst", 64'({m_axi_bready, m_axi_rready}), 64'(0));
    chk("t6_busy_done_after_rst", 64'({busy, done}), 64'(0));
    rst = 1'b0;
    cfg_b_dly = 0; cfg_ar_dly = 0; cfg_rdata = 32'h0; cfg_rresp = 2'b00;
    tick();
    set_client(0, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
    set_client(1, 1'b0, 32'h0000_0064, 32'h0, 4'h0);
    ar_q.push_back(32'h0000_0060);
    ar_q.push_back(32'h0000_0064);
    expect_done(0, 32'h0000_0060, 2'b00, 1'b0);
    expect_done(1, 32'h0000_0064, 2'b00, 1'b0);
    req = 2'b11;
    wait_idle("t6_post_rst_complete", 200);

    repeat (4) tick();
    chk("scoreboard_drained", 64'(exp_q.size() + aw_q.size() + w_q.size() + ar_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
- Shares the single AXI4-Lite master port of the SiTCP top among N_REQ simple-request clients, e.g. the RBCP bridge path and a TCP-stream command decoder.
- Arbitrates round-robin and runs exactly one AXI-Lite transaction at a time.
- Sequences the AW/W/B or AR/R handshakes and returns data and response to the granted client.
- Sits between the requesters and the 8-to-32 adapter / AXI interconnect, in the m_axi_aclk domain.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; strobe width is DATA_W/8.
- TIMEOUT, 1023, cycles to wait for any single handshake before the arbiter aborts.

Ports:
- clk  in  1  clock (m_axi_aclk, 200 MHz)
- rst  in  1  synchronous active-high reset
- req  in  N_REQ  per-client request; held high until that client's done pulse
- req_we  in  N_REQ  per-client 1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses; client i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data
- req_wstrb  in  N_REQ*DATA_W/8  packed write strobes
- done  out  N_REQ  one-cycle completion pulse for the granted client
- rdata  out  DATA_W  read data; valid with done, shared by all clients
- resp  out  2  AXI response, or 2'b11 on timeout; valid with done
- timeout_err  out  1  one-cycle pulse with done when the transaction was aborted
- busy  out  1  high from grant until done
- m_axi_aw{addr,prot,valid} out, m_axi_awready in  write address channel (prot fixed 3'b000)
- m_axi_w{data,strb,valid} out, m_axi_wready in  write data channel
- m_axi_b{resp,valid} in, m_axi_bready out  write response channel
- m_axi_ar{addr,prot,valid} out, m_axi_arready in  read address channel (prot fixed 3'b000)
- m_axi_r{data,resp,valid} in, m_axi_rready out  read data channel

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - all m_axi valid/ready outputs = 0; done = 0; busy = 0; timeout_err = 0
  - rdata = 0; resp = 0; address/data outputs = 0
  - round-robin pointer = N_REQ-1, so client 0 wins first.
- State machine: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - If any req bit is high, pick the first requesting index scanning from ptr+1 (mod N_REQ).
  - Register its we/addr/wdata/wstrb; set ptr = winner; busy = 1.
  - Go to WR (we=1) or RD_ADDR (we=0).
  - Address/valid outputs appear the cycle after the req is sampled, so latency from req to awvalid/arvalid is 1 cycle.
- WR:
  - awvalid and wvalid rise together.
  - Each drops independently on its own ready handshake; awready and wready may arrive in either order or the same cycle.
  - Once both handshakes have completed, go to WR_RESP with bready = 1.
- WR_RESP: on bvalid, capture bresp and go to DONE; bready = 0 from the next cycle.
- RD_ADDR: arvalid = 1; on arready, go to RD_DATA with rready = 1.
- RD_DATA: on rvalid, capture rdata/rresp and go to DONE.
- DONE:
  - done[ptr] = 1 for one cycle, with rdata/resp valid; busy = 0 next cycle; return to IDLE.
  - rdata holds its value until the next read completes; on writes rdata is unchanged.
- Back-to-back: a client re-asserting req right after done is not re-granted ahead of other waiting clients (rotation is from ptr+1). The minimum gap between transactions is 1 IDLE cycle.
- Timeout:
  - A counter clears on entry to every state except IDLE/DONE and counts while that state's handshake is pending.
  - On reaching TIMEOUT: drop all valids/readys, go to DONE with resp = 2'b11 and timeout_err = 1.
  - A late bvalid/rvalid arriving afterwards is ignored: bready/rready are 0 in IDLE.
- Req dropped mid-transaction: the transaction completes anyway, and done is still pulsed.
- Simultaneous requests: resolved strictly round-robin; no starvation, worst-case wait is N_REQ-1 transactions.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The in-flight AXI transaction is abandoned; the system-wide reset clears the slave.
- m_axi outputs are registered; no combinational path from any m_axi ready/valid input to any m_axi output.

Decomposition:
- Shared package axi_sitcp_pkg:
  - state enum
  - AXI response constants: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11 (also used as the timeout response)
  - AXI_PROT_DEFAULT = 3'b000
- Sub-module rr_arbiter (N_REQ): req vector + ptr in, one-hot grant + index out; purely combinational. The FSM owns ptr.

Test Plan:
- Single write from client 0 (addr 0x0000_0010, data 0xDEAD_BEEF, strb 0xF); slave asserts awready before wready, bresp OKAY -> exactly one AW and one W handshake with those values, done[0] pulses once, resp = 0, busy drops.
- Single read from client 1 (addr 0x0000_0020); slave returns 0x1234_5678, rresp 2'b10 -> done[1] pulses, rdata = 0x1234_5678, resp = 2'b10, no AW activity.
- Both clients request reads continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; never two outstanding; arvalid is 1 cycle after each IDLE.
- Write where wready comes 3 cycles before awready, then both in the same cycle on a second write -> each valid drops the cycle after its own handshake; bready is asserted only after both handshakes.
- Slave never asserts arready, TIMEOUT = 15 -> arvalid drops after 15 cycles, done pulses with resp = 2'b11 and timeout_err = 1; a later rvalid is ignored and the next request proceeds normally.
- rst asserted during WR_RESP -> next cycle all valids/readys = 0, busy = 0, no done pulse; a client 0 request after reset is granted first.
